vld_rdy_buf_2w1r: RTL and testbench
===================================

Name: vld_rdy_buf_2w1r

Overview:
Wide-to-narrow serializer on the test_io valid/ready path.
- Accepts one wide word of NUM_BEATS*DATA_WIDTH bits and emits it as NUM_BEATS narrow beats, lowest slice first.
- Sits directly upstream of the narrow-to-wide gather buffer (vld_rdy_buf_1w2r), so a wide host word can be split, moved over a narrow link and reassembled.
- Beat ordering matches the gather buffer: beat i equals data_in[i*DATA_WIDTH +: DATA_WIDTH].

Parameters:
- DATA_WIDTH, 32, width of one narrow output beat.
- NUM_BEATS, 2, narrow beats per wide input word; must be >= 2.
- CNT_WIDTH, $clog2(NUM_BEATS), beat index width; derived, not overridden.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  synchronous reset, active-high.
- slave_valid  input  1  wide word valid.
- slave_ready  output  1  wide word accept.
- data_in  input  NUM_BEATS*DATA_WIDTH  wide word; slice i is beat i.
- slave_beats  input  CNT_WIDTH+1  beats to send; present only with the optional feature.
- master_valid  output  1  narrow beat valid.
- master_ready  input  1  narrow beat accept.
- data_out  output  DATA_WIDTH  current narrow beat.
- master_last  output  1  current beat is the final beat of its word.

Behaviour:
- Reset:
  - Clock and reset: one clock; reset is synchronous and active-high.
  - While rst=1 at a posedge: state<=IDLE, beat_idx<=0, end_idx<=NUM_BEATS-1.
  - While rst=1: master_valid=0, master_last=0, slave_ready=0.
  - Holding register is not reset. data_out is don't-care while master_valid=0.
- Handshakes:
  - Input transfer wr_en = slave_valid & slave_ready.
  - Output transfer rd_en = master_valid & master_ready.
  - master_valid, data_out and master_last hold stable while master_valid=1 and master_ready=0.
  - slave_valid may depend on nothing from this block.
- State machine has two states:
  - IDLE: master_valid=0; slave_ready=~rst. On wr_en: hold<=data_in, beat_idx<=0, end_idx<=NUM_BEATS-1, go to SEND.
  - SEND: master_valid=1; data_out=hold[beat_idx*DATA_WIDTH +: DATA_WIDTH]; master_last=(beat_idx==end_idx).
    - rd_en & ~master_last: beat_idx<=beat_idx+1.
    - rd_en & master_last & ~wr_en: go to IDLE, beat_idx<=0.
    - rd_en & master_last & wr_en: reload hold, beat_idx<=0, end_idx from the new word, stay in SEND. Back-to-back words have no bubble.
- slave_ready in SEND = master_last & master_ready & ~rst. This is a combinational path from master_ready, as in the gather buffer.
- Latency and throughput:
  - First beat is visible on master_valid the cycle after wr_en.
  - Sustained throughput is one beat per cycle.
  - A full word occupies NUM_BEATS cycles when master_ready is held at 1.
- Width rules:
  - beat_idx never exceeds end_idx, so there is no wrap-around.
  - Arithmetic is CNT_WIDTH bits wide, with explicit sizing on constants.
- Reset mid-word: remaining beats are discarded, with no partial flush. The first post-reset word starts at beat 0.

Optional Feature:
Macro VLD_RDY_BUF_2W1R_BEATS_EN.
- Defined:
  - Port slave_beats exists and is sampled on wr_en.
  - end_idx <= min(slave_beats, NUM_BEATS) - 1.
  - slave_beats=0 is treated as NUM_BEATS.
  - A short word ends with master_last on beat end_idx and never emits higher slices.
- Not defined:
  - Port slave_beats is absent.
  - end_idx is constant NUM_BEATS-1 and every word emits exactly NUM_BEATS beats.

Test Plan:
- Reset then single word: rst=1 for 2 cycles, then data_in=64'hBBBB_0002_AAAA_0001 with master_ready=1.
  - Required: slave_ready=0 during reset.
  - Required: 32'hAAAA_0001 (last=0), then 32'hBBBB_0002 (last=1), on consecutive cycles starting the cycle after accept.
  - Required: master_valid=0 afterwards.
- Back-to-back: slave_valid=1 continuously with words W0 and W1, master_ready=1.
  - Required: 4 consecutive beats W0[31:0], W0[63:32], W1[31:0], W1[63:32] with no idle cycle.
  - Required: slave_ready=1 only in the cycles with last beat and master_ready=1.
- Backpressure: master_ready=0 for 3 cycles mid-word.
  - Required: data_out, master_valid and master_last are constant.
  - Required: slave_ready=0; no beat skipped or repeated.
- Reset mid-word: assert rst after beat 0 of W0 is taken.
  - Required: next cycle master_valid=0.
  - Required: the next accepted word W1 starts with W1[31:0].
- NUM_BEATS=4 with gather buffer (FIFO_DEPTH=4) downstream, random valid/ready at 50%, 100 words.
  - Required: reassembled wide word equals input word in order.
- With VLD_RDY_BUF_2W1R_BEATS_EN and NUM_BEATS=4:
  - slave_beats=2 gives exactly 2 beats, last on beat 1.
  - slave_beats=0 gives 4 beats.
  - slave_beats=7 gives 4 beats.

Source files
------------

// File: rtl/vld_rdy_buf_2w1r_if.sv
// Handshake bundle for the wide-to-narrow serializer; slave_beats exists only
// when VLD_RDY_BUF_2W1R_BEATS_EN is defined. slave = serializer view, master = driver view.
interface vld_rdy_buf_2w1r_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_BEATS  = 2
);
    logic                            slave_valid;
    logic                            slave_ready;
    logic [NUM_BEATS*DATA_WIDTH-1:0] data_in;
`ifdef VLD_RDY_BUF_2W1R_BEATS_EN
    logic [$clog2(NUM_BEATS):0]      slave_beats;
`endif
    logic                            master_valid;
    logic                            master_ready;
    logic [DATA_WIDTH-1:0]           data_out;
    logic                            master_last;

    modport slave (
        input  slave_valid, data_in, master_ready,
`ifdef VLD_RDY_BUF_2W1R_BEATS_EN
        input  slave_beats,
`endif
        output slave_ready, master_valid, data_out, master_last
    );

    modport master (
        output slave_valid, data_in, master_ready,
`ifdef VLD_RDY_BUF_2W1R_BEATS_EN
        output slave_beats,
`endif
        input  slave_ready, master_valid, data_out, master_last
    );
endinterface

// File: rtl/vld_rdy_buf_2w1r.sv
// Wide-to-narrow serializer: one NUM_BEATS*DATA_WIDTH word out as NUM_BEATS beats, slice 0 first.
// Optional VLD_RDY_BUF_2W1R_BEATS_EN adds slave_beats to send short words.
module vld_rdy_buf_2w1r #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_BEATS  = 2
) (
    input  logic              clk,
    input  logic              rst,
    vld_rdy_buf_2w1r_if.slave bus
);
    localparam int unsigned CNT_WIDTH = $clog2(NUM_BEATS);
    localparam logic [CNT_WIDTH-1:0] LAST_IDX = CNT_WIDTH'(NUM_BEATS - 1);

    typedef enum logic {IDLE, SEND} state_e;

    state_e                               state_q, state_d;
    logic [NUM_BEATS-1:0][DATA_WIDTH-1:0] hold_q;
    logic [CNT_WIDTH-1:0]                 beat_idx_q, beat_idx_d;
    logic [CNT_WIDTH-1:0]                 end_idx_q, end_idx_d;
    logic [CNT_WIDTH-1:0]                 new_end_c;
    logic                                 load_c;
    logic                                 sready_c;
    logic                                 mvalid_c;
    logic                                 mlast_c;

`ifdef VLD_RDY_BUF_2W1R_BEATS_EN
    localparam int unsigned BW = CNT_WIDTH + 1;
    logic [CNT_WIDTH:0] beats_c;

    // Zero or oversize beat counts mean a full word.
    always_comb begin
        beats_c = bus.slave_beats;
        if (bus.slave_beats == '0 || bus.slave_beats > BW'(NUM_BEATS)) begin
            beats_c = BW'(NUM_BEATS);
        end
        new_end_c = CNT_WIDTH'(beats_c - BW'(1));
    end
`else
    assign new_end_c = LAST_IDX;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            beat_idx_q <= '0;
            end_idx_q  <= LAST_IDX;
        end else begin
            state_q    <= state_d;
            beat_idx_q <= beat_idx_d;
            end_idx_q  <= end_idx_d;
        end
    end

    // Holding register is intentionally not reset.
    always_ff @(posedge clk) begin
        if (load_c) begin
            hold_q <= bus.data_in;
        end
    end

    always_comb begin
        state_d    = state_q;
        beat_idx_d = beat_idx_q;
        end_idx_d  = end_idx_q;
        load_c     = 1'b0;
        sready_c   = 1'b0;
        mvalid_c   = 1'b0;
        mlast_c    = 1'b0;
        case (state_q)
            IDLE: begin
                sready_c = 1'b1;
                if (bus.slave_valid) begin
                    load_c     = 1'b1;
                    beat_idx_d = '0;
                    end_idx_d  = new_end_c;
                    state_d    = SEND;
                end
            end
            SEND: begin
                mvalid_c = 1'b1;
                mlast_c  = (beat_idx_q == end_idx_q);
                // Accept the next word only as the final beat leaves: no bubble between words.
                sready_c = mlast_c & bus.master_ready;
                if (bus.master_ready) begin
                    if (!mlast_c) begin
                        beat_idx_d = beat_idx_q + CNT_WIDTH'(1);
                    end else begin
                        beat_idx_d = '0;
                        if (bus.slave_valid) begin
                            load_c    = 1'b1;
                            end_idx_d = new_end_c;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (rst) begin
            load_c   = 1'b0;
            sready_c = 1'b0;
            mvalid_c = 1'b0;
            mlast_c  = 1'b0;
        end
    end

    assign bus.slave_ready  = sready_c;
    assign bus.master_valid = mvalid_c;
    assign bus.master_last  = mlast_c;
    assign bus.data_out     = hold_q[beat_idx_q];
endmodule

// File: tb/tb_vld_rdy_buf_2w1r.sv
// Bench for vld_rdy_buf_2w1r: directed 2-beat cases plus a randomized 4-beat run
// against a beat-queue reference model (honours VLD_RDY_BUF_2W1R_BEATS_EN).
module tb_vld_rdy_buf_2w1r;
`ifdef VLD_RDY_BUF_2W1R_BEATS_EN
    localparam bit BEATS_EN = 1'b1;
`else
    localparam bit BEATS_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    vld_rdy_buf_2w1r_if #(.DATA_WIDTH(32), .NUM_BEATS(2)) if2 ();
    vld_rdy_buf_2w1r_if #(.DATA_WIDTH(32), .NUM_BEATS(4)) if4 ();

    vld_rdy_buf_2w1r #(.DATA_WIDTH(32), .NUM_BEATS(2)) dut2 (.clk(clk), .rst(rst), .bus(if2));
    vld_rdy_buf_2w1r #(.DATA_WIDTH(32), .NUM_BEATS(4)) dut4 (.clk(clk), .rst(rst), .bus(if4));

    int n_tests = 0;
    int n_fail  = 0;

    logic [32:0] q4[$];          // pending beats {last, data} for the 4-beat instance
    int          words_in4  = 0;
    int          words_out4 = 0;
    int          beats_seen = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic in2(input logic sv, input logic [63:0] d, input logic mr);
        if2.slave_valid  = sv;
        if2.data_in      = d;
        if2.master_ready = mr;
    endtask

    task automatic exp2(input string tag, input logic mv, input logic [31:0] d,
                        input logic l, input logic sr);
        chk({tag, "_valid"}, 64'(if2.master_valid), 64'(mv));
        chk({tag, "_ready"}, 64'(if2.slave_ready), 64'(sr));
        if (mv) begin
            chk({tag, "_data"}, 64'(if2.data_out), 64'(d));
            chk({tag, "_last"}, 64'(if2.master_last), 64'(l));
        end
    endtask

    function automatic int eff_beats(input logic [2:0] nb);
        if (!BEATS_EN || nb == 3'd0 || nb > 3'd4) return 4;
        return int'(nb);
    endfunction

    // One cycle on the 4-beat instance: entered and left at posedge+1.
    task automatic cycle4(input logic sv, input logic [127:0] d, input logic [2:0] nb,
                          input logic mr, output bit acc);
        logic [32:0] head;
        bit          exp_sr;
        int          n;
        if4.slave_valid  = sv;
        if4.data_in      = d;
        if4.master_ready = mr;
`ifdef VLD_RDY_BUF_2W1R_BEATS_EN
        if4.slave_beats  = nb;
`endif
        #1;
        exp_sr = (q4.size() == 0) || (q4.size() == 1 && mr);
        chk("b4_ready", 64'(if4.slave_ready), 64'(exp_sr));
        chk("b4_valid", 64'(if4.master_valid), 64'(q4.size() != 0));
        if (if4.master_valid && mr) beats_seen++;
        if (q4.size() != 0) begin
            head = q4[0];
            chk("b4_data", 64'(if4.data_out), 64'(head[31:0]));
            chk("b4_last", 64'(if4.master_last), 64'(head[32]));
            if (mr) begin
                void'(q4.pop_front());
                if (head[32]) words_out4++;
            end
        end
        acc = sv && exp_sr;
        if (acc) begin
            n = eff_beats(nb);
            for (int i = 0; i < n; i++) q4.push_back({(i == n - 1), d[i*32 +: 32]});
            words_in4++;
        end
        @(posedge clk); #1;
    endtask

    initial begin
        logic [63:0]  wa, w0, w1, w2, w4, w5;
        logic [127:0] rd;
        logic [2:0]   rnb;
        bit           pend, acc;
        int           nb_tab[3];
        int           exp_tab[3];

        wa = 64'hBBBB_0002_AAAA_0001;
        w0 = 64'hCAFE_0001_BEEF_0000;
        w1 = 64'h1234_5678_9ABC_DEF0;
        w2 = 64'h0F0F_2222_F0F0_1111;
        w4 = 64'hDEAD_0044_DEAD_0040;
        w5 = 64'h5555_0051_5555_0050;
        in2(1'b0, 64'd0, 1'b0);
        if4.slave_valid  = 1'b0;
        if4.data_in      = '0;
        if4.master_ready = 1'b0;
`ifdef VLD_RDY_BUF_2W1R_BEATS_EN
        if4.slave_beats  = '0;
`endif

        // Reset for two edges, then a single word
        @(posedge clk); #1; in2(1'b1, wa, 1'b1); #1; exp2("rst0", 0, 0, 0, 0);
        @(posedge clk); #2; exp2("rst1", 0, 0, 0, 0);
        @(posedge clk); #1; rst = 1'b0; #1; exp2("single_acc", 0, 0, 0, 1);
        @(posedge clk); #1; in2(1'b0, 64'd0, 1'b1); #1; exp2("single_b0", 1, 32'hAAAA_0001, 0, 0);
        @(posedge clk); #2; exp2("single_b1", 1, 32'hBBBB_0002, 1, 1);
        @(posedge clk); #2; exp2("single_idle", 0, 0, 0, 1);

        // Back-to-back words with no bubble
        @(posedge clk); #1; in2(1'b1, w0, 1'b1); #1; exp2("b2b_acc", 0, 0, 0, 1);
        @(posedge clk); #1; in2(1'b1, w1, 1'b1); #1; exp2("b2b_w0b0", 1, w0[31:0], 0, 0);
        @(posedge clk); #2; exp2("b2b_w0b1", 1, w0[63:32], 1, 1);
        @(posedge clk); #1; in2(1'b0, 64'd0, 1'b1); #1; exp2("b2b_w1b0", 1, w1[31:0], 0, 0);
        @(posedge clk); #2; exp2("b2b_w1b1", 1, w1[63:32], 1, 1);
        @(posedge clk); #2; exp2("b2b_idle", 0, 0, 0, 1);

        // Backpressure on beat 0 for three cycles
        @(posedge clk); #1; in2(1'b1, w2, 1'b1); #1; exp2("bp_acc", 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1; in2(1'b0, 64'd0, 1'b0); #1; exp2("bp_stall", 1, w2[31:0], 0, 0);
        end
        @(posedge clk); #1; in2(1'b0, 64'd0, 1'b1); #1; exp2("bp_rel_b0", 1, w2[31:0], 0, 0);
        @(posedge clk); #2; exp2("bp_b1", 1, w2[63:32], 1, 1);
        @(posedge clk); #2; exp2("bp_idle", 0, 0, 0, 1);

        // Reset after beat 0 is taken; next word starts at slice 0
        @(posedge clk); #1; in2(1'b1, w4, 1'b1); #1; exp2("rm_acc", 0, 0, 0, 1);
        @(posedge clk); #1; in2(1'b0, 64'd0, 1'b1); #1; exp2("rm_b0", 1, w4[31:0], 0, 0);
        @(posedge clk); #1; rst = 1'b1; #1; exp2("rm_in_rst", 0, 0, 0, 0);
        @(posedge clk); #1; rst = 1'b0; in2(1'b1, w5, 1'b1); #1; exp2("rm_idle", 0, 0, 0, 1);
        @(posedge clk); #1; in2(1'b0, 64'd0, 1'b1); #1; exp2("rm_w5b0", 1, w5[31:0], 0, 0);
        @(posedge clk); #2; exp2("rm_w5b1", 1, w5[63:32], 1, 1);
        @(posedge clk); #2; exp2("rm_end", 0, 0, 0, 1);

        // Randomized 4-beat run, 100 words, ~50% valid/ready
        @(posedge clk); #1;
        pend = 1'b0;
        rd   = '0;
        rnb  = '0;
        for (int c = 0; c < 5000 && (words_in4 < 100 || q4.size() != 0); c++) begin
            if (!pend && words_in4 < 100 && $urandom_range(0, 1) == 1) begin
                pend = 1'b1;
                rd   = {$urandom(), $urandom(), $urandom(), $urandom()};
                rnb  = 3'($urandom_range(0, 7));
            end
            cycle4(pend, rd, rnb, 1'($urandom_range(0, 1)), acc);
            if (acc) pend = 1'b0;
        end
        chk("rand_words_in", 64'(words_in4), 64'd100);
        chk("rand_words_out", 64'(words_out4), 64'd100);
        chk("rand_drained", 64'(q4.size()), 64'd0);

        // Beat-count limits: 2, 0 and 7 requested
        nb_tab  = '{2, 0, 7};
        exp_tab = '{2, 4, 4};
        for (int t = 0; t < 3; t++) begin
            beats_seen = 0;
            rd = {$urandom(), $urandom(), $urandom(), $urandom()};
            cycle4(1'b1, rd, 3'(nb_tab[t]), 1'b1, acc);
            for (int k = 0; k < 6; k++) cycle4(1'b0, '0, 3'd0, 1'b1, acc);
            chk("beats_count", 64'(beats_seen), 64'(BEATS_EN ? exp_tab[t] : 4));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
